// File: rtl/tile_blitter_pkg.sv
// Shared types and helpers for the tile blitter: FSM states, fetch tag layout, flip transform.
package tile_blitter_pkg;

    localparam int unsigned CHAN_IDX_W = 2;
    localparam int unsigned POS_W      = 8;
    localparam int unsigned POS_EXT_W  = POS_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    // Travels alongside each ROM read so the returning byte knows where it belongs.
    typedef struct packed {
        logic                  valid;
        logic [CHAN_IDX_W-1:0] chan_idx;
        logic                  last_chan;
        logic [POS_W-1:0]      col;
        logic [POS_W-1:0]      row;
    } tag_t;

    localparam tag_t TAG_IDLE = '0;

    // Mirror a tile-local coordinate inside a span of 'size' pixels when flip is set.
    function automatic logic [POS_W-1:0] flip_coord(input logic [POS_W-1:0]     pos,
                                                    input logic [POS_EXT_W-1:0] size,
                                                    input logic                 flip);
        logic [POS_EXT_W-1:0] mirrored;
        mirrored = size - POS_EXT_W'(pos) - POS_EXT_W'(1);
        return flip ? mirrored[POS_W-1:0] : pos;
    endfunction

endpackage

// File: rtl/tile_blitter_rom_fetch_pipe.sv
// Delay line that keeps fetch tags aligned with tile ROM read data.
module tile_blitter_rom_fetch_pipe
    import tile_blitter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    // Shift tags one stage per cycle; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= TAG_IDLE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/tile_blitter.sv
// Tile blitter: streams a tile from ROM and writes its pixels to the shared VGA bus.
module tile_blitter
    import tile_blitter_pkg::*;
#(
    parameter int unsigned TILE_W      = 8,
    parameter int unsigned TILE_H      = 8,
    parameter int unsigned COORD_W     = 8,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned CHAN        = 3,
    parameter int unsigned CHAN_W      = 8,
    parameter int unsigned ROM_LATENCY = 2,
    parameter bit          KEY_EN      = 1'b1,
    parameter logic [CHAN*CHAN_W-1:0] KEY_RGB = 24'hFF00FF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   draw,
    input  logic [ADDR_W-1:0]      tile_address,
    input  logic [COORD_W-1:0]     x_pos,
    input  logic [COORD_W-1:0]     y_pos,
    input  logic                   flip_h,
    input  logic                   flip_v,
    output logic [ADDR_W-1:0]      rom_request_address,
    input  logic [CHAN_W-1:0]      rom_request_data,
    output logic                   active,
    output logic                   done,
    output logic                   vga_draw_enable_bus,
    output logic [COORD_W-1:0]     vga_x_out_bus,
    output logic [COORD_W-1:0]     vga_y_out_bus,
    output logic [CHAN*CHAN_W-1:0] vga_RGB_out_bus
);

    localparam int unsigned PIX_W = CHAN * CHAN_W;
    localparam int unsigned COL_W = $clog2(TILE_W);
    localparam int unsigned ROW_W = $clog2(TILE_H) + 1;

    state_t                  state;
    logic [COORD_W-1:0]      x_lat;
    logic [COORD_W-1:0]      y_lat;
    logic                    fh_lat;
    logic                    fv_lat;
    logic [CHAN_IDX_W-1:0]   chan_cnt;
    logic [COL_W-1:0]        col_cnt;
    logic [ROW_W-1:0]        row_cnt;

    logic [PIX_W-1:0]        asm_q;
    logic                    draw_en_q;
    logic [COORD_W-1:0]      x_q;
    logic [COORD_W-1:0]      y_q;
    logic [PIX_W-1:0]        rgb_q;

    tag_t                    fetch_tag_c;
    tag_t                    tag_out;
    logic                    last_chan_c;
    logic                    last_col_c;
    logic                    last_row_c;
    logic [PIX_W-1:0]        pixel_c;
    logic                    emit_c;
    logic                    last_pix_c;
    logic                    key_hit_c;

    assign last_chan_c = (chan_cnt == CHAN_IDX_W'(CHAN - 1));
    assign last_col_c  = (col_cnt == COL_W'(TILE_W - 1));
    assign last_row_c  = (row_cnt == ROW_W'(TILE_H - 1));

    // Tag describing the byte requested this cycle.
    always_comb begin
        fetch_tag_c = TAG_IDLE;
        if (state == S_FETCH) begin
            fetch_tag_c.valid     = 1'b1;
            fetch_tag_c.chan_idx  = chan_cnt;
            fetch_tag_c.last_chan = last_chan_c;
            fetch_tag_c.col       = POS_W'(col_cnt);
            fetch_tag_c.row       = POS_W'(row_cnt);
        end
    end

    tile_blitter_rom_fetch_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_rom_fetch_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (fetch_tag_c),
        .tag_out (tag_out)
    );

    // Merge the returning byte into its channel slot; channel 0 occupies the MSBs.
    always_comb begin
        pixel_c = asm_q;
        for (int i = 0; i < int'(CHAN); i++) begin
            if (tag_out.chan_idx == CHAN_IDX_W'(i)) begin
                pixel_c[PIX_W-1-i*CHAN_W -: CHAN_W] = rom_request_data;
            end
        end
    end

    assign emit_c     = tag_out.valid && tag_out.last_chan;
    assign last_pix_c = emit_c && (tag_out.col == POS_W'(TILE_W - 1))
                               && (tag_out.row == POS_W'(TILE_H - 1));
    assign key_hit_c  = KEY_EN && (pixel_c == KEY_RGB);

    // Sequencer: latch the request, walk the ROM one byte per cycle, wait for the tail, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            active              <= 1'b0;
            done                <= 1'b0;
            rom_request_address <= '0;
            x_lat               <= '0;
            y_lat               <= '0;
            fh_lat              <= 1'b0;
            fv_lat              <= 1'b0;
            chan_cnt            <= '0;
            col_cnt             <= '0;
            row_cnt             <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (draw) begin
                        rom_request_address <= tile_address;
                        x_lat               <= x_pos;
                        y_lat               <= y_pos;
                        fh_lat              <= flip_h;
                        fv_lat              <= flip_v;
                        chan_cnt            <= '0;
                        col_cnt             <= '0;
                        row_cnt             <= '0;
                        active              <= 1'b1;
                        state               <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rom_request_address <= rom_request_address + ADDR_W'(1);
                    if (last_chan_c) begin
                        chan_cnt <= '0;
                        if (last_col_c) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + ROW_W'(1);
                        end else begin
                            col_cnt <= col_cnt + COL_W'(1);
                        end
                    end else begin
                        chan_cnt <= chan_cnt + CHAN_IDX_W'(1);
                    end
                    if (last_chan_c && last_col_c && last_row_c) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pix_c) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done   <= 1'b1;
                    active <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel assembly and output registers; keyed pixels update position/colour but do not strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q     <= '0;
            draw_en_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= '0;
        end else begin
            draw_en_q <= 1'b0;
            if (tag_out.valid) begin
                asm_q <= pixel_c;
            end
            if (emit_c) begin
                rgb_q     <= pixel_c;
                x_q       <= x_lat + COORD_W'(flip_coord(tag_out.col, POS_EXT_W'(TILE_W), fh_lat));
                y_q       <= y_lat + COORD_W'(flip_coord(tag_out.row, POS_EXT_W'(TILE_H), fv_lat));
                draw_en_q <= !key_hit_c;
            end
        end
    end

    // Release the shared bus whenever this blitter is not drawing.
    assign vga_draw_enable_bus = active ? draw_en_q : 1'bz;
    assign vga_x_out_bus       = active ? x_q       : {COORD_W{1'bz}};
    assign vga_y_out_bus       = active ? y_q       : {COORD_W{1'bz}};
    assign vga_RGB_out_bus     = active ? rgb_q     : {PIX_W{1'bz}};

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter: default 8x8 RGB instance plus a 16x4 mono, latency-4 instance.
module tb_tile_blitter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        draw_a, draw_b;
    logic [11:0] tile_address;
    logic [7:0]  x_pos, y_pos;
    logic        flip_h, flip_v;

    logic [11:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic        active_a, active_b, done_a, done_b;
    wire         en_a, en_b;
    wire  [7:0]  vx_a, vy_a, vx_b, vy_b;
    wire  [23:0] rgb_a;
    wire  [7:0]  rgb_b;

    tile_blitter dut_a (
        .clk(clk), .reset(reset), .draw(draw_a), .tile_address(tile_address),
        .x_pos(x_pos), .y_pos(y_pos), .flip_h(flip_h), .flip_v(flip_v),
        .rom_request_address(addr_a), .rom_request_data(data_a),
        .active(active_a), .done(done_a), .vga_draw_enable_bus(en_a),
        .vga_x_out_bus(vx_a), .vga_y_out_bus(vy_a), .vga_RGB_out_bus(rgb_a)
    );

    tile_blitter #(
        .TILE_W(16), .TILE_H(4), .CHAN(1), .ROM_LATENCY(4), .KEY_RGB(8'hFF)
    ) dut_b (
        .clk(clk), .reset(reset), .draw(draw_b), .tile_address(tile_address),
        .x_pos(x_pos), .y_pos(y_pos), .flip_h(flip_h), .flip_v(flip_v),
        .rom_request_address(addr_b), .rom_request_data(data_b),
        .active(active_b), .done(done_b), .vga_draw_enable_bus(en_b),
        .vga_x_out_bus(vx_b), .vga_y_out_bus(vy_b), .vga_RGB_out_bus(rgb_b)
    );

    // Tile ROM model with the latency each instance expects.
    logic [7:0] rom [4096];
    logic [7:0] pipe_a [2];
    logic [7:0] pipe_b [4];
    always @(posedge clk) begin
        pipe_a[0] <= rom[addr_a];
        pipe_a[1] <= pipe_a[0];
        pipe_b[0] <= rom[addr_b];
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign data_a = pipe_a[1];
    assign data_b = pipe_b[3];

    int vectors = 0;
    int miscompares = 0;

    // Results of the most recent blit.
    int          s_idx [$];
    logic [7:0]  s_x   [$];
    logic [7:0]  s_y   [$];
    logic [23:0] s_rgb [$];
    int          done_cnt, done_idx;
    bit          timed_out, aborted;
    logic        ab_active, ab_done, ab_en;
    logic [11:0] ab_addr;

    // Start a blit and record every strobe (sample index = negedges after entering S_FETCH).
    task automatic run_blit(input bit sel, input logic [11:0] ta, input logic [7:0] x,
                            input logic [7:0] y, input bit fh, input bit fv,
                            input int abort_at, input int ignore_at);
        logic        en, dn;
        s_idx.delete(); s_x.delete(); s_y.delete(); s_rgb.delete();
        done_cnt = 0; done_idx = -1; timed_out = 0; aborted = 0;
        @(negedge clk);
        tile_address = ta; x_pos = x; y_pos = y; flip_h = fh; flip_v = fv;
        if (sel) draw_b = 1'b1; else draw_a = 1'b1;
        @(negedge clk);
        draw_a = 1'b0; draw_b = 1'b0;
        for (int idx = 0; idx < 600; idx++) begin
            en = sel ? en_b : en_a;
            dn = sel ? done_b : done_a;
            if (en === 1'b1) begin
                s_idx.push_back(idx);
                s_x.push_back(sel ? vx_b : vx_a);
                s_y.push_back(sel ? vy_b : vy_a);
                s_rgb.push_back(sel ? {16'h0, rgb_b} : rgb_a);
            end
            if (dn === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            draw_a = 1'b0; draw_b = 1'b0;
            if (idx == ignore_at) begin
                x_pos = 8'd99;
                if (sel) draw_b = 1'b1; else draw_a = 1'b1;
            end
            if (idx == abort_at) begin
                reset = 1'b1;
                #1;
                ab_active = sel ? active_b : active_a;
                ab_done   = sel ? done_b : done_a;
                ab_en     = sel ? en_b : en_a;
                ab_addr   = sel ? addr_b : addr_a;
                aborted   = 1;
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            if (done_idx >= 0 && idx >= done_idx + 3) break;
            @(negedge clk);
        end
        draw_a = 1'b0; draw_b = 1'b0;
        if (done_idx < 0 && !aborted) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; draw_a = 1'b0; draw_b = 1'b0;
        tile_address = '0; x_pos = '0; y_pos = '0; flip_h = 1'b0; flip_v = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (active_a !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b exp 0", active_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done_a); end
        vectors++; if (addr_a !== 12'h000) begin miscompares++; $display("FAIL reset_addr got %h exp 000", addr_a); end
        vectors++; if (en_a === 1'b1) begin miscompares++; $display("FAIL reset_strobe got %b exp not 1", en_a); end
        vectors++; if (active_b !== 1'b0) begin miscompares++; $display("FAIL reset_active_b got %b exp 0", active_b); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (active_a !== 1'b0) begin miscompares++; $display("FAIL idle_active got %b exp 0", active_a); end
    endtask

    task automatic test_basic();
        int r, c;
        logic [23:0] exp_rgb;
        run_blit(0, 12'h000, 8'd10, 8'd20, 0, 0, -1, -1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout got no done exp done"); end
        vectors++; if (s_idx.size() != 64) begin miscompares++; $display("FAIL basic_count got %0d exp 64", s_idx.size()); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
        vectors++; if (done_idx != 195) begin miscompares++; $display("FAIL basic_done_at got %0d exp 195", done_idx); end
        for (int p = 0; p < 64 && p < s_idx.size(); p++) begin
            r = p / 8; c = p % 8;
            exp_rgb = {8'(3*p), 8'(3*p+1), 8'(3*p+2)};
            vectors++; if (s_idx[p] != 5 + 3*p) begin miscompares++; $display("FAIL basic_time p=%0d got %0d exp %0d", p, s_idx[p], 5+3*p); end
            vectors++; if (s_x[p] !== 8'(10 + c) || s_y[p] !== 8'(20 + r)) begin miscompares++;
                $display("FAIL basic_xy p=%0d got (%0d,%0d) exp (%0d,%0d)", p, s_x[p], s_y[p], 10+c, 20+r); end
            vectors++; if (s_rgb[p] !== exp_rgb) begin miscompares++; $display("FAIL basic_rgb p=%0d got %h exp %h", p, s_rgb[p], exp_rgb); end
        end
        vectors++; if (active_a !== 1'b0) begin miscompares++; $display("FAIL basic_active_after got %b exp 0", active_a); end
    endtask

    task automatic test_flip();
        int r, c;
        logic [23:0] exp_rgb;
        run_blit(0, 12'h000, 8'd10, 8'd20, 1, 1, -1, -1);
        vectors++; if (s_idx.size() != 64) begin miscompares++; $display("FAIL flip_count got %0d exp 64", s_idx.size()); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL flip_done_cnt got %0d exp 1", done_cnt); end
        for (int p = 0; p < 64 && p < s_idx.size(); p++) begin
            r = p / 8; c = p % 8;
            exp_rgb = {8'(3*p), 8'(3*p+1), 8'(3*p+2)};
            vectors++; if (s_x[p] !== 8'(17 - c) || s_y[p] !== 8'(27 - r)) begin miscompares++;
                $display("FAIL flip_xy p=%0d got (%0d,%0d) exp (%0d,%0d)", p, s_x[p], s_y[p], 17-c, 27-r); end
            vectors++; if (s_rgb[p] !== exp_rgb) begin miscompares++; $display("FAIL flip_rgb p=%0d got %h exp %h", p, s_rgb[p], exp_rgb); end
        end
    endtask

    task automatic test_wrap();
        run_blit(0, 12'h000, 8'd252, 8'd254, 0, 0, -1, -1);
        vectors++; if (s_idx.size() != 64) begin miscompares++; $display("FAIL wrap_count got %0d exp 64", s_idx.size()); end
        for (int p = 0; p < 64 && p < s_idx.size(); p++) begin
            vectors++; if (s_idx[p] != 5 + 3*p) begin miscompares++; $display("FAIL wrap_time p=%0d got %0d exp %0d", p, s_idx[p], 5+3*p); end
            vectors++; if (s_x[p] !== 8'(252 + p % 8) || s_y[p] !== 8'(254 + p / 8)) begin miscompares++;
                $display("FAIL wrap_xy p=%0d got (%0d,%0d) exp (%0d,%0d)", p, s_x[p], s_y[p], (252+p%8)%256, (254+p/8)%256); end
        end
        if (s_idx.size() > 20) begin
            vectors++; if (s_x[20] !== 8'd0 || s_y[20] !== 8'd0) begin miscompares++;
                $display("FAIL wrap_origin got (%0d,%0d) exp (0,0)", s_x[20], s_y[20]); end
        end
    endtask

    task automatic test_key();
        int j;
        rom[15] = 8'hFF; rom[16] = 8'h00; rom[17] = 8'hFF;
        rom[27] = 8'hFF; rom[28] = 8'h00; rom[29] = 8'hFF;
        run_blit(0, 12'h000, 8'd10, 8'd20, 0, 0, -1, -1);
        vectors++; if (s_idx.size() != 62) begin miscompares++; $display("FAIL key_count got %0d exp 62", s_idx.size()); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL key_done_cnt got %0d exp 1", done_cnt); end
        j = 0;
        for (int p = 0; p < 64; p++) begin
            if (p == 5 || p == 9) continue;
            if (j >= s_idx.size()) break;
            vectors++; if (s_idx[j] != 5 + 3*p || s_x[j] !== 8'(10 + p % 8) || s_y[j] !== 8'(20 + p / 8)) begin miscompares++;
                $display("FAIL key_pix p=%0d got t=%0d (%0d,%0d) exp t=%0d (%0d,%0d)", p, s_idx[j], s_x[j], s_y[j], 5+3*p, 10+p%8, 20+p/8); end
            j++;
        end
        for (int i = 15; i < 18; i++) rom[i] = 8'(i);
        for (int i = 27; i < 30; i++) rom[i] = 8'(i);
    endtask

    task automatic test_reset_mid();
        run_blit(0, 12'h000, 8'd10, 8'd20, 0, 0, 95, -1);
        vectors++; if (!aborted) begin miscompares++; $display("FAIL mid_abort got not reached exp reached"); end
        vectors++; if (ab_active !== 1'b0) begin miscompares++; $display("FAIL mid_active got %b exp 0", ab_active); end
        vectors++; if (ab_done !== 1'b0) begin miscompares++; $display("FAIL mid_done got %b exp 0", ab_done); end
        vectors++; if (ab_en === 1'b1) begin miscompares++; $display("FAIL mid_strobe got %b exp not 1", ab_en); end
        vectors++; if (ab_addr !== 12'h000) begin miscompares++; $display("FAIL mid_addr got %h exp 000", ab_addr); end
        vectors++; if (s_idx.size() != 31 || done_cnt != 0) begin miscompares++;
            $display("FAIL mid_progress got %0d strobes %0d done exp 31 strobes 0 done", s_idx.size(), done_cnt); end
        repeat (3) @(negedge clk);
        vectors++; if (done_a !== 1'b0 || active_a !== 1'b0) begin miscompares++;
            $display("FAIL mid_quiet got done=%b active=%b exp 0 0", done_a, active_a); end
        test_basic();
    endtask

    task automatic test_lat4();
        run_blit(1, 12'h000, 8'd30, 8'd40, 0, 0, -1, 20);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL lat4_timeout got no done exp done"); end
        vectors++; if (s_idx.size() != 64) begin miscompares++; $display("FAIL lat4_count got %0d exp 64", s_idx.size()); end
        vectors++; if (done_cnt != 1 || done_idx != 69) begin miscompares++;
            $display("FAIL lat4_done got cnt=%0d at %0d exp cnt=1 at 69", done_cnt, done_idx); end
        for (int p = 0; p < 64 && p < s_idx.size(); p++) begin
            vectors++; if (s_idx[p] != 5 + p) begin miscompares++; $display("FAIL lat4_time p=%0d got %0d exp %0d", p, s_idx[p], 5+p); end
            vectors++; if (s_x[p] !== 8'(30 + p % 16) || s_y[p] !== 8'(40 + p / 16) || s_rgb[p] !== 24'(p)) begin miscompares++;
                $display("FAIL lat4_pix p=%0d got (%0d,%0d) %h exp (%0d,%0d) %h", p, s_x[p], s_y[p], s_rgb[p], 30+p%16, 40+p/16, p); end
        end
        vectors++; if (active_b !== 1'b0) begin miscompares++; $display("FAIL lat4_active_after got %b exp 0", active_b); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i);
        test_reset();
        test_basic();
        test_flip();
        test_wrap();
        test_key();
        test_reset_mid();
        test_lat4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

endmodule
